// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - pipelined main control with load-use stall, MEM branch flush and ID jump
module pipelined_controller #(
  parameter int OPW       = 6,
  parameter int AW        = 5,
  parameter int ALUOPW    = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [OPW-1:0]    ID_OpCode,
  input  logic [AW-1:0]     ID_Rs,
  input  logic [AW-1:0]     ID_Rt,
  input  logic              MEM_Zero,
  output logic              EX_RegDst,
  output logic              EX_ALUSrc,
  output logic              EX_ZeroExt,
  output logic [ALUOPW-1:0] EX_ALUOp,
  output logic              MEM_MemRead,
  output logic              MEM_MemWrite,
  output logic              MEM_Branch,
  output logic              WB_RegWrite,
  output logic              WB_MemToReg,
  output logic              PCSrc,
  output logic              Jump,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              IllegalOp
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b001001);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(6'b011100);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b001110);
  localparam logic [OPW-1:0] OP_SAD   = OPW'(6'b011111);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'b001011);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  typedef struct packed {
    logic              reg_write;
    logic              reg_dst;
    logic              alu_src;
    logic              zero_ext;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [ALUOPW-1:0] alu_op;
    logic              branch;
    logic              is_bne;
  } ctrl_t;

  ctrl_t             dec;
  logic [6:0]        dec_flags;
  logic [3:0]        dec_aluop;
  logic              dec_branch;
  logic              dec_bne;
  logic              dec_j;
  logic              dec_illegal;
  logic              reads_rs;
  logic              reads_rt;

  ctrl_t             ex_ctrl;
  logic [AW-1:0]     ex_rt;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic              mem_branch;
  logic              mem_is_bne;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              illegal_op;

  logic              active;
  logic              pc_src;
  logic              hazard_match;
  logic              stall;
  logic              jump;

  // Opcode decode; flags are {RegWrite, RegDst, ALUSrc, ZeroExt, MemRead, MemWrite, MemToReg}
  always_comb begin
    dec_flags   = 7'b0000000;
    dec_aluop   = 4'b0000;
    dec_branch  = 1'b0;
    dec_bne     = 1'b0;
    dec_j       = 1'b0;
    dec_illegal = 1'b0;
    reads_rs    = 1'b1;
    reads_rt    = 1'b0;
    case (ID_OpCode)
      OP_RTYPE:          begin dec_flags = 7'b1100001; dec_aluop = 4'b0000; reads_rt = 1'b1; end
      OP_ADDI, OP_ADDIU: begin dec_flags = 7'b1010001; dec_aluop = 4'b0001; end
      OP_MUL:            begin dec_flags = 7'b1100001; dec_aluop = 4'b0010; reads_rt = 1'b1; end
      OP_ANDI:           begin dec_flags = 7'b1011001; dec_aluop = 4'b0011; end
      OP_ORI:            begin dec_flags = 7'b1011001; dec_aluop = 4'b0100; end
      OP_XORI:           begin dec_flags = 7'b1011001; dec_aluop = 4'b0101; end
      OP_SAD:            begin dec_flags = 7'b1100001; dec_aluop = 4'b0011; reads_rt = 1'b1; end
      OP_SLTI, OP_SLTIU: begin dec_flags = 7'b1010001; dec_aluop = 4'b0110; end
      OP_LW:             begin dec_flags = 7'b1010100; dec_aluop = 4'b0001; end
      OP_SW:             begin dec_flags = 7'b0010010; dec_aluop = 4'b0001; reads_rt = 1'b1; end
      OP_BEQ:            begin dec_branch = 1'b1; dec_aluop = 4'b0111; reads_rt = 1'b1; end
      OP_BNE:            begin dec_branch = 1'b1; dec_bne = 1'b1; dec_aluop = 4'b0111; reads_rt = 1'b1; end
      OP_J:              begin dec_j = 1'b1; reads_rs = 1'b0; end
      default:           begin dec_illegal = 1'b1; reads_rs = 1'b0; end
    endcase
    dec.reg_write  = dec_flags[6];
    dec.reg_dst    = dec_flags[5];
    dec.alu_src    = dec_flags[4];
    dec.zero_ext   = dec_flags[3];
    dec.mem_read   = dec_flags[2];
    dec.mem_write  = dec_flags[1];
    dec.mem_to_reg = dec_flags[0];
    dec.alu_op     = ALUOPW'(dec_aluop);
    dec.branch     = dec_branch;
    dec.is_bne     = dec_bne;
  end

  // Redirect and hazard resolution; branch in MEM outranks a stall, a stall outranks a jump
  always_comb begin
    active       = ~Rst & En;
    pc_src       = active & mem_branch & (MEM_Zero ^ mem_is_bne);
    hazard_match = ex_ctrl.mem_read &
                   (((ex_rt == ID_Rs) & reads_rs) | ((ex_rt == ID_Rt) & reads_rt));
    stall        = HAZARD_EN & active & ~pc_src & hazard_match;
    jump         = active & dec_j & ~stall & ~pc_src;
  end

  // ID/EX: bubble on branch flush, load-use stall or jump redirect
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_ctrl <= '0;
      ex_rt   <= '0;
    end else if (En) begin
      if (pc_src | stall | jump) begin
        ex_ctrl <= '0;
        ex_rt   <= '0;
      end else begin
        ex_ctrl <= dec;
        ex_rt   <= ID_Rt;
      end
    end
  end

  // EX/MEM: the instruction behind a taken branch is squashed
  always_ff @(posedge Clk) begin
    if (Rst || (En && pc_src)) begin
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_branch     <= 1'b0;
      mem_is_bne     <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
    end else if (En) begin
      mem_mem_read   <= ex_ctrl.mem_read;
      mem_mem_write  <= ex_ctrl.mem_write;
      mem_branch     <= ex_ctrl.branch;
      mem_is_bne     <= ex_ctrl.is_bne;
      mem_reg_write  <= ex_ctrl.reg_write;
      mem_mem_to_reg <= ex_ctrl.mem_to_reg;
    end
  end

  // MEM/WB: the branch itself always retires
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else if (En) begin
      wb_reg_write  <= mem_reg_write;
      wb_mem_to_reg <= mem_mem_to_reg;
    end
  end

  // Undecoded opcode flag, registered alongside the ID/EX load
  always_ff @(posedge Clk) begin
    if (Rst) begin
      illegal_op <= 1'b0;
    end else if (En) begin
      illegal_op <= dec_illegal;
    end
  end

  assign EX_RegDst    = ex_ctrl.reg_dst;
  assign EX_ALUSrc    = ex_ctrl.alu_src;
  assign EX_ZeroExt   = ex_ctrl.zero_ext;
  assign EX_ALUOp     = ex_ctrl.alu_op;
  assign MEM_MemRead  = mem_mem_read;
  assign MEM_MemWrite = mem_mem_write;
  assign MEM_Branch   = mem_branch;
  assign WB_RegWrite  = wb_reg_write;
  assign WB_MemToReg  = wb_mem_to_reg;
  assign PCSrc        = pc_src;
  assign Jump         = jump;
  assign PCWrite      = Rst | (En & ~stall);
  assign IFIDWrite    = Rst | (En & ~stall);
  assign IFIDFlush    = pc_src | jump;
  assign IllegalOp    = illegal_op;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb/tb_pipelined_controller.sv - directed and randomized check of pipelined_controller against a stage model
module tb_pipelined_controller;

  logic       Clk = 1'b0;
  logic       Rst, En, MEM_Zero;
  logic [5:0] ID_OpCode;
  logic [4:0] ID_Rs, ID_Rt;

  logic       EX_RegDst, EX_ALUSrc, EX_ZeroExt;
  logic [3:0] EX_ALUOp;
  logic       MEM_MemRead, MEM_MemWrite, MEM_Branch, WB_RegWrite, WB_MemToReg;
  logic       PCSrc, Jump, PCWrite, IFIDWrite, IFIDFlush, IllegalOp;

  logic       h0_EX_RegDst, h0_EX_ALUSrc, h0_EX_ZeroExt;
  logic [3:0] h0_EX_ALUOp;
  logic       h0_MEM_MemRead, h0_MEM_MemWrite, h0_MEM_Branch, h0_WB_RegWrite, h0_WB_MemToReg;
  logic       h0_PCSrc, h0_Jump, h0_PCWrite, h0_IFIDWrite, h0_IFIDFlush, h0_IllegalOp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  pipelined_controller #(.HAZARD_EN(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .ID_OpCode(ID_OpCode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .MEM_Zero(MEM_Zero), .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_ZeroExt(EX_ZeroExt),
    .EX_ALUOp(EX_ALUOp), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Branch(MEM_Branch), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
    .PCSrc(PCSrc), .Jump(Jump), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IllegalOp(IllegalOp)
  );

  pipelined_controller #(.HAZARD_EN(1'b0)) dut_nohaz (
    .Clk(Clk), .Rst(Rst), .En(En), .ID_OpCode(ID_OpCode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .MEM_Zero(MEM_Zero), .EX_RegDst(h0_EX_RegDst), .EX_ALUSrc(h0_EX_ALUSrc),
    .EX_ZeroExt(h0_EX_ZeroExt), .EX_ALUOp(h0_EX_ALUOp), .MEM_MemRead(h0_MEM_MemRead),
    .MEM_MemWrite(h0_MEM_MemWrite), .MEM_Branch(h0_MEM_Branch), .WB_RegWrite(h0_WB_RegWrite),
    .WB_MemToReg(h0_WB_MemToReg), .PCSrc(h0_PCSrc), .Jump(h0_Jump), .PCWrite(h0_PCWrite),
    .IFIDWrite(h0_IFIDWrite), .IFIDFlush(h0_IFIDFlush), .IllegalOp(h0_IllegalOp)
  );

  // Reference model: one record per instruction occupying a stage
  typedef struct packed {
    bit       rw, rd, as, ze, mr, mw, mtr;
    bit [3:0] aluop;
    bit       br, bne;
    bit [4:0] rt;
  } stage_t;

  typedef struct packed {
    stage_t s;
    bit     j, ill, rrs, rrt;
  } info_t;

  stage_t m_ex, m_mem, m_wb;
  bit     m_ill;
  info_t  m_dec;
  bit     e_pcsrc, e_stall, e_jump, e_pcw, e_ifw, e_flush;

  // Rows copied from the decode table: RegWrite RegDst ALUSrc ZeroExt MemRead MemWrite MemToReg ALUOp
  function automatic info_t decode(input bit [5:0] op);
    info_t      r;
    bit [10:0]  row;
    r   = '0;
    row = '0;
    r.rrs = 1'b1;
    case (op)
      6'b000000:            begin row = 11'b1100001_0000; r.rrt = 1'b1; end
      6'b001000, 6'b001001: row = 11'b1010001_0001;
      6'b011100:            begin row = 11'b1100001_0010; r.rrt = 1'b1; end
      6'b001100:            row = 11'b1011001_0011;
      6'b001101:            row = 11'b1011001_0100;
      6'b001110:            row = 11'b1011001_0101;
      6'b011111:            begin row = 11'b1100001_0011; r.rrt = 1'b1; end
      6'b001010, 6'b001011: row = 11'b1010001_0110;
      6'b100011:            row = 11'b1010100_0001;
      6'b101011:            begin row = 11'b0010010_0001; r.rrt = 1'b1; end
      6'b000100:            begin row = 11'b0000000_0111; r.s.br = 1'b1; r.rrt = 1'b1; end
      6'b000101:            begin row = 11'b0000000_0111; r.s.br = 1'b1; r.s.bne = 1'b1; r.rrt = 1'b1; end
      6'b000010:            begin r.j = 1'b1; r.rrs = 1'b0; end
      default:              begin r.ill = 1'b1; r.rrs = 1'b0; end
    endcase
    {r.s.rw, r.s.rd, r.s.as, r.s.ze, r.s.mr, r.s.mw, r.s.mtr, r.s.aluop} = row;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit live, hit;
    m_dec      = decode(ID_OpCode);
    m_dec.s.rt = ID_Rt;
    live    = !Rst && En;
    e_pcsrc = live && m_mem.br && (MEM_Zero != m_mem.bne);
    hit     = (m_ex.rt == ID_Rs && m_dec.rrs) || (m_ex.rt == ID_Rt && m_dec.rrt);
    e_stall = live && !e_pcsrc && m_ex.mr && hit;
    e_jump  = live && m_dec.j && !e_stall && !e_pcsrc;
    e_pcw   = Rst || (En && !e_stall);
    e_ifw   = Rst || (En && !e_stall);
    e_flush = e_pcsrc || e_jump;
  endtask

  task automatic model_edge();
    if (Rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;
    end else if (En) begin
      m_wb  = m_mem;
      m_mem = e_pcsrc ? '0 : m_ex;
      m_ex  = (e_pcsrc || e_stall || e_jump) ? '0 : m_dec.s;
      m_ill = m_dec.ill;
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit [5:0] op,
                       input bit [4:0] rs, input bit [4:0] rt, input bit z);
    Rst = rst; En = en; ID_OpCode = op; ID_Rs = rs; ID_Rt = rt; MEM_Zero = z;
    #1;
    model_comb();
    chk("PCSrc", PCSrc, e_pcsrc);
    chk("Jump", Jump, e_jump);
    chk("PCWrite", PCWrite, e_pcw);
    chk("IFIDWrite", IFIDWrite, e_ifw);
    chk("IFIDFlush", IFIDFlush, e_flush);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("EX_RegDst", EX_RegDst, m_ex.rd);
    chk("EX_ALUSrc", EX_ALUSrc, m_ex.as);
    chk("EX_ZeroExt", EX_ZeroExt, m_ex.ze);
    chk("EX_ALUOp", EX_ALUOp, m_ex.aluop);
    chk("MEM_MemRead", MEM_MemRead, m_mem.mr);
    chk("MEM_MemWrite", MEM_MemWrite, m_mem.mw);
    chk("MEM_Branch", MEM_Branch, m_mem.br);
    chk("WB_RegWrite", WB_RegWrite, m_wb.rw);
    chk("WB_MemToReg", WB_MemToReg, m_wb.mtr);
    chk("IllegalOp", IllegalOp, m_ill);
  endtask

  bit [5:0] ops [15] = '{6'h00, 6'h08, 6'h09, 6'h1c, 6'h0c, 6'h0d, 6'h0e, 6'h1f,
                         6'h0a, 6'h0b, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;

    // reset
    drive(1, 1, 6'h00, 0, 0, 0);
    chk("rst_pcwrite", PCWrite, 1);
    chk("rst_pcsrc", PCSrc, 0);
    step();
    chk("rst_ex_aluop", EX_ALUOp, 0);
    chk("rst_wb_regwrite", WB_RegWrite, 0);

    // addi then R-type
    drive(0, 1, 6'h08, 1, 2, 0); step();
    chk("addi_ex_alusrc", EX_ALUSrc, 1);
    chk("addi_ex_aluop", EX_ALUOp, 4'b0001);
    drive(0, 1, 6'h00, 3, 4, 0); step();
    drive(0, 1, 6'h00, 3, 4, 0); step();
    chk("addi_wb_regwrite", WB_RegWrite, 1);
    chk("addi_wb_memtoreg", WB_MemToReg, 1);

    // lw rt=5 then add rs=5, with and without hazard logic
    drive(0, 1, 6'h23, 1, 5, 0); step();
    drive(0, 1, 6'h00, 5, 2, 0);
    chk("lu_pcwrite", PCWrite, 0);
    chk("lu_ifidwrite", IFIDWrite, 0);
    chk("lu_nohaz_pcwrite", h0_PCWrite, 1);
    chk("lu_nohaz_ifidwrite", h0_IFIDWrite, 1);
    step();
    chk("lu_bubble_regdst", EX_RegDst, 0);
    chk("lu_nohaz_regdst", h0_EX_RegDst, 1);
    drive(0, 1, 6'h00, 5, 2, 0);
    chk("lu_resume", PCWrite, 1);
    step();
    chk("lu_add_in_ex", EX_RegDst, 1);

    // beq taken in MEM flushes EX and MEM
    drive(0, 1, 6'h04, 1, 2, 0); step();
    drive(0, 1, 6'h2b, 1, 2, 0); step();
    drive(0, 1, 6'h08, 1, 2, 1);
    chk("beq_pcsrc", PCSrc, 1);
    chk("beq_flush", IFIDFlush, 1);
    step();
    chk("beq_ex_alusrc", EX_ALUSrc, 0);
    chk("beq_mem_memwrite", MEM_MemWrite, 0);

    // bne with zero set is not taken
    drive(0, 1, 6'h05, 1, 2, 1); step();
    drive(0, 1, 6'h00, 1, 2, 1); step();
    drive(0, 1, 6'h00, 1, 2, 1);
    chk("bne_pcsrc", PCSrc, 0);
    step();

    // undecoded opcode
    drive(0, 1, 6'h3f, 1, 2, 0); step();
    chk("ill_pulse", IllegalOp, 1);
    chk("ill_ex_regdst", EX_RegDst, 0);
    drive(0, 1, 6'h08, 1, 2, 0); step();
    chk("ill_clear", IllegalOp, 0);

    // jump behind a stalling lw
    drive(0, 1, 6'h23, 1, 5, 0); step();
    drive(0, 1, 6'h00, 5, 2, 0);
    chk("jstall_jump", Jump, 0);
    step();
    drive(0, 1, 6'h00, 5, 2, 0); step();
    drive(0, 1, 6'h02, 5, 2, 0);
    chk("jump_taken", Jump, 1);
    chk("jump_flush", IFIDFlush, 1);
    step();

    // reset mid-sequence
    drive(0, 1, 6'h08, 1, 2, 0); step();
    drive(0, 1, 6'h23, 3, 4, 0); step();
    drive(1, 1, 6'h00, 1, 2, 0);
    chk("midrst_pcwrite", PCWrite, 1);
    step();
    chk("midrst_ex_alusrc", EX_ALUSrc, 0);
    chk("midrst_mem_memread", MEM_MemRead, 0);
    chk("midrst_wb_regwrite", WB_RegWrite, 0);

    // enable low freezes everything
    drive(0, 1, 6'h08, 1, 2, 0); step();
    drive(0, 0, 6'h02, 1, 2, 0);
    chk("en0_pcwrite", PCWrite, 0);
    chk("en0_jump", Jump, 0);
    step();
    chk("en0_hold", EX_ALUSrc, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit [5:0] op;
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 14)];
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), op,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
